last_fetched_store_table: RTL and testbench
===========================================

Name: last_fetched_store_table

Overview:
- Store-set LFST in the RNDS stage, directly downstream of ID. It consumes the per-slot store set IDs that ID produces from the SSIT.
- Each entry records the tag of the most recently dispatched, not-yet-issued store in that store set. Dual-slot loads and stores look the table up to get a memory-dependence tag.
- The resulting dependence is registered into the RNDS/issue boundary. Stores overwrite their set's entry; the entry is invalidated when that store issues.

Parameters:
- LFST_WIDTH, 7, store set ID width; table depth = 2**LFST_WIDTH.
- TAG_WIDTH, 5, store tag width (ROB index of the store).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- instrN_valid  in  1  slot N (N=0,1) holds a valid instruction this cycle
- instrN_is_load  in  1  slot N is a load
- instrN_is_store  in  1  slot N is a store
- instrN_ssid_valid  in  1  slot N has an assigned store set
- instrN_ssid  in  LFST_WIDTH  store set ID from ID stage
- instrN_tag  in  TAG_WIDTH  slot N's allocated tag
- rnds_stall  in  1  hold stage; no dispatch updates
- rnds_flush  in  1  pipeline recovery flush
- st_issue_valid  in  1  a store issued this cycle
- st_issue_ssid  in  LFST_WIDTH  issued store's set ID
- st_issue_tag  in  TAG_WIDTH  issued store's tag
- instrN_dep_valid  out  1  registered: slot N must wait on instrN_dep_tag
- instrN_dep_tag  out  TAG_WIDTH  registered producer store tag

Behaviour:
- Storage: per entry, valid bit plus TAG_WIDTH tag. Valid bits are a flop vector so flush clears them in one cycle.
- On rst: all entry valids = 0; both dep_valid = 0, both dep_tag = 0. Tag contents are don't-care.
- Slot N is active when instrN_valid & instrN_ssid_valid & (is_load | is_store).
- Lookup is combinational in cycle T. Results are registered and visible at T+1, giving 1-cycle latency.
- Slot 0 lookup: hit = entry[ssid0].valid and not killed by this cycle's invalidate. dep0 = hit, tag = entry tag.
- Invalidate kill in the same cycle: st_issue_valid & ssid match & entry tag == st_issue_tag.
- Slot 1 intra-bundle bypass: if slot 0 is an active store with ssid0 == ssid1, dep1 = 1 and tag1 = instr0_tag. Otherwise slot 1 does the same lookup as slot 0.
- Table write, only when !rnds_stall & !rnds_flush: an active store writes entry[ssid] <= {1, tag}.
- Both slots stores to the same ssid: slot 1 write wins.
- Invalidate: when st_issue_valid, the entry at st_issue_ssid is cleared only if valid and its tag == st_issue_tag. A newer store's entry is never cleared.
- Invalidate vs dispatch write to the same entry in the same cycle: the dispatch write wins.
- Invalidate still acts during rnds_stall.
- Output registers:
  - rnds_flush: both dep_valid <= 0; the table is fully invalidated; flush dominates stall, write and invalidate.
  - rnds_stall: hold outputs, except a held dep_valid drops to 0 when st_issue_valid and st_issue_tag == the held dep_tag.
  - Otherwise: capture the lookup result. A slot that is inactive gets dep_valid <= 0 and dep_tag <= 0.
- Tags compare by equality only; there is no wrap/age arithmetic. Tag uniqueness among in-flight stores is guaranteed by the ROB.
- Reset mid-operation behaves identically to power-on reset.

Test Plan:
1. Load before any store: slot0 load ssid=5 -> next cycle dep0_valid=0, dep0_tag=0.
2. Store then load across cycles:
   - Cycle 1: slot0 store ssid=5, tag=3.
   - Cycle 2: slot0 load ssid=5 -> cycle 3 dep0_valid=1, dep0_tag=3.
3. Intra-bundle bypass and write priority:
   - Same cycle: slot0 store ssid=9 tag=4, slot1 load ssid=9 -> dep1_valid=1, dep1_tag=4.
   - Same cycle: slot0 store ssid=9 tag=6, slot1 store ssid=9 tag=7 -> a later load on ssid=9 gets tag=7.
4. Invalidate rules:
   - Entry ssid=2 holds tag=8; st_issue ssid=2 tag=8 -> a later load on ssid=2 gets dep_valid=0.
   - Repeat with st_issue tag=1 -> the entry survives; the later load gets tag=8.
   - Same-cycle load lookup on ssid=2 with the matching issue -> dep_valid=0.
5. Stall behaviour:
   - Stall with dep0_valid=1, tag=3 held; st_issue tag=3 -> dep0_valid drops to 0.
   - A store presented during the stall does not write its entry.
6. Flush and write-vs-invalidate:
   - Populate ssids 1, 2, 3; assert rnds_flush -> all outputs 0; later loads on ssids 1-3 get dep_valid=0.
   - Same-cycle dispatch store ssid=4 tag=10 with st_issue ssid=4 tag=(old) -> entry = tag 10, valid.

Source files
------------

// File: rtl/last_fetched_store_table.sv
`default_nettype none
// ============================================================================
// Module      : last_fetched_store_table
// Description : Store-set LFST for the RNDS stage. Tracks the tag of the most
//               recent dispatched, not-yet-issued store per store set and
//               produces a registered memory-dependence tag for two slots.
// Revision    : 1.0 - initial release
// ============================================================================
module last_fetched_store_table #(
    parameter int LFST_WIDTH = 7,
    parameter int TAG_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr0_valid,
    input  logic                  instr0_is_load,
    input  logic                  instr0_is_store,
    input  logic                  instr0_ssid_valid,
    input  logic [LFST_WIDTH-1:0] instr0_ssid,
    input  logic [TAG_WIDTH-1:0]  instr0_tag,
    input  logic                  instr1_valid,
    input  logic                  instr1_is_load,
    input  logic                  instr1_is_store,
    input  logic                  instr1_ssid_valid,
    input  logic [LFST_WIDTH-1:0] instr1_ssid,
    input  logic [TAG_WIDTH-1:0]  instr1_tag,
    input  logic                  rnds_stall,
    input  logic                  rnds_flush,
    input  logic                  st_issue_valid,
    input  logic [LFST_WIDTH-1:0] st_issue_ssid,
    input  logic [TAG_WIDTH-1:0]  st_issue_tag,
    output logic                  instr0_dep_valid,
    output logic [TAG_WIDTH-1:0]  instr0_dep_tag,
    output logic                  instr1_dep_valid,
    output logic [TAG_WIDTH-1:0]  instr1_dep_tag
);

    localparam int c_DEPTH = 2 ** LFST_WIDTH;

    // Valid bits are a plain flop vector so a flush clears the whole table at once.
    logic [c_DEPTH-1:0]   r_valid;
    logic [TAG_WIDTH-1:0] r_tag [c_DEPTH];

    logic                 r_dep0_valid;
    logic [TAG_WIDTH-1:0] r_dep0_tag;
    logic                 r_dep1_valid;
    logic [TAG_WIDTH-1:0] r_dep1_tag;

    logic                 w_active0;
    logic                 w_active1;
    logic                 w_store0;
    logic                 w_store1;
    logic                 w_issue_hit;
    logic                 w_hit0;
    logic                 w_hit1;
    logic                 w_bypass1;
    logic                 w_dep0_valid;
    logic [TAG_WIDTH-1:0] w_dep0_tag;
    logic                 w_dep1_valid;
    logic [TAG_WIDTH-1:0] w_dep1_tag;
    logic                 w_dispatch;

    assign w_active0  = instr0_valid & instr0_ssid_valid & (instr0_is_load | instr0_is_store);
    assign w_active1  = instr1_valid & instr1_ssid_valid & (instr1_is_load | instr1_is_store);
    assign w_store0   = w_active0 & instr0_is_store;
    assign w_store1   = w_active1 & instr1_is_store;
    assign w_dispatch = ~rnds_stall & ~rnds_flush;

    // The issuing store still owns its set's entry (a newer store would have
    // replaced the tag), so the entry is retired this cycle.
    assign w_issue_hit = st_issue_valid & r_valid[st_issue_ssid]
                       & (r_tag[st_issue_ssid] == st_issue_tag);

    // A lookup that lands on the entry being retired this cycle sees it as empty.
    assign w_hit0 = r_valid[instr0_ssid]
                  & ~(w_issue_hit & (st_issue_ssid == instr0_ssid));
    assign w_hit1 = r_valid[instr1_ssid]
                  & ~(w_issue_hit & (st_issue_ssid == instr1_ssid));

    // An older store in the same bundle is newer than anything in the table.
    assign w_bypass1 = w_store0 & (instr0_ssid == instr1_ssid);

    // Lookup result per slot; inactive or missing slots report a zero tag.
    always_comb begin
        w_dep0_valid = 1'b0;
        w_dep0_tag   = '0;
        w_dep1_valid = 1'b0;
        w_dep1_tag   = '0;
        if (w_active0 && w_hit0) begin
            w_dep0_valid = 1'b1;
            w_dep0_tag   = r_tag[instr0_ssid];
        end
        if (w_active1) begin
            if (w_bypass1) begin
                w_dep1_valid = 1'b1;
                w_dep1_tag   = instr0_tag;
            end else if (w_hit1) begin
                w_dep1_valid = 1'b1;
                w_dep1_tag   = r_tag[instr1_ssid];
            end
        end
    end

    // Entry valid bits: flush clears all; dispatch writes override a same-cycle retire.
    always_ff @(posedge clk) begin
        if (rst || rnds_flush) begin
            r_valid <= '0;
        end else begin
            if (w_issue_hit) begin
                r_valid[st_issue_ssid] <= 1'b0;
            end
            if (w_dispatch && w_store0) begin
                r_valid[instr0_ssid] <= 1'b1;
            end
            if (w_dispatch && w_store1) begin
                r_valid[instr1_ssid] <= 1'b1;
            end
        end
    end

    // Entry tags: written by dispatched stores only, slot 1 last so it wins.
    always_ff @(posedge clk) begin
        if (!rst && w_dispatch) begin
            if (w_store0) begin
                r_tag[instr0_ssid] <= instr0_tag;
            end
            if (w_store1) begin
                r_tag[instr1_ssid] <= instr1_tag;
            end
        end
    end

    // RNDS/issue boundary registers; a held dependence is released when its store issues.
    always_ff @(posedge clk) begin
        if (rst || rnds_flush) begin
            r_dep0_valid <= 1'b0;
            r_dep0_tag   <= '0;
            r_dep1_valid <= 1'b0;
            r_dep1_tag   <= '0;
        end else if (rnds_stall) begin
            if (st_issue_valid && (st_issue_tag == r_dep0_tag)) begin
                r_dep0_valid <= 1'b0;
            end
            if (st_issue_valid && (st_issue_tag == r_dep1_tag)) begin
                r_dep1_valid <= 1'b0;
            end
        end else begin
            r_dep0_valid <= w_dep0_valid;
            r_dep0_tag   <= w_dep0_tag;
            r_dep1_valid <= w_dep1_valid;
            r_dep1_tag   <= w_dep1_tag;
        end
    end

    assign instr0_dep_valid = r_dep0_valid;
    assign instr0_dep_tag   = r_dep0_tag;
    assign instr1_dep_valid = r_dep1_valid;
    assign instr1_dep_tag   = r_dep1_tag;

endmodule
`default_nettype wire

// File: tb/tb_last_fetched_store_table.sv
`default_nettype none
// ============================================================================
// Module      : tb_last_fetched_store_table
// Description : Directed and randomized bench for last_fetched_store_table,
//               checked against a per-set "youngest live store" model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_last_fetched_store_table;

    localparam int LW = 7;
    localparam int TW = 5;
    localparam int NS = 2 ** LW;

    logic          clk = 1'b0;
    logic          rst;
    logic          instr0_valid, instr0_is_load, instr0_is_store, instr0_ssid_valid;
    logic [LW-1:0] instr0_ssid;
    logic [TW-1:0] instr0_tag;
    logic          instr1_valid, instr1_is_load, instr1_is_store, instr1_ssid_valid;
    logic [LW-1:0] instr1_ssid;
    logic [TW-1:0] instr1_tag;
    logic          rnds_stall, rnds_flush, st_issue_valid;
    logic [LW-1:0] st_issue_ssid;
    logic [TW-1:0] st_issue_tag;
    logic          instr0_dep_valid, instr1_dep_valid;
    logic [TW-1:0] instr0_dep_tag, instr1_dep_tag;

    int checks   = 0;
    int failures = 0;

    // Model: for each store set, whether a live store exists and its tag.
    bit            m_live [NS];
    logic [TW-1:0] m_tag  [NS];
    bit            e_v0, e_v1;
    logic [TW-1:0] e_t0, e_t1;

    last_fetched_store_table #(.LFST_WIDTH(LW), .TAG_WIDTH(TW)) dut (
        .clk(clk), .rst(rst),
        .instr0_valid(instr0_valid), .instr0_is_load(instr0_is_load),
        .instr0_is_store(instr0_is_store), .instr0_ssid_valid(instr0_ssid_valid),
        .instr0_ssid(instr0_ssid), .instr0_tag(instr0_tag),
        .instr1_valid(instr1_valid), .instr1_is_load(instr1_is_load),
        .instr1_is_store(instr1_is_store), .instr1_ssid_valid(instr1_ssid_valid),
        .instr1_ssid(instr1_ssid), .instr1_tag(instr1_tag),
        .rnds_stall(rnds_stall), .rnds_flush(rnds_flush),
        .st_issue_valid(st_issue_valid), .st_issue_ssid(st_issue_ssid),
        .st_issue_tag(st_issue_tag),
        .instr0_dep_valid(instr0_dep_valid), .instr0_dep_tag(instr0_dep_tag),
        .instr1_dep_valid(instr1_dep_valid), .instr1_dep_tag(instr1_dep_tag)
    );

    always #5 clk = ~clk;

    task automatic idle();
        rst = 1'b0; rnds_stall = 1'b0; rnds_flush = 1'b0;
        st_issue_valid = 1'b0; st_issue_ssid = '0; st_issue_tag = '0;
        instr0_valid = 1'b0; instr0_is_load = 1'b0; instr0_is_store = 1'b0;
        instr0_ssid_valid = 1'b0; instr0_ssid = '0; instr0_tag = '0;
        instr1_valid = 1'b0; instr1_is_load = 1'b0; instr1_is_store = 1'b0;
        instr1_ssid_valid = 1'b0; instr1_ssid = '0; instr1_tag = '0;
    endtask

    task automatic slot0(input bit ld, input bit st, input int ss, input int tg);
        instr0_valid = 1'b1; instr0_ssid_valid = 1'b1;
        instr0_is_load = ld; instr0_is_store = st;
        instr0_ssid = LW'(ss); instr0_tag = TW'(tg);
    endtask

    task automatic slot1(input bit ld, input bit st, input int ss, input int tg);
        instr1_valid = 1'b1; instr1_ssid_valid = 1'b1;
        instr1_is_load = ld; instr1_is_store = st;
        instr1_ssid = LW'(ss); instr1_tag = TW'(tg);
    endtask

    task automatic issue(input int ss, input int tg);
        st_issue_valid = 1'b1; st_issue_ssid = LW'(ss); st_issue_tag = TW'(tg);
    endtask

    // What a memory op in a slot depends on: the youngest live store of its set,
    // unless that store is leaving this very cycle.
    function automatic void look(input bit act, input int ss, input bit retire,
                                 output bit v, output logic [TW-1:0] t);
        v = 1'b0; t = '0;
        if (act && m_live[ss] && !(retire && st_issue_ssid == LW'(ss))) begin
            v = 1'b1; t = m_tag[ss];
        end
    endfunction

    task automatic model_step();
        bit a0, a1, s0, s1, retire;
        a0 = instr0_valid && instr0_ssid_valid && (instr0_is_load || instr0_is_store);
        a1 = instr1_valid && instr1_ssid_valid && (instr1_is_load || instr1_is_store);
        s0 = a0 && instr0_is_store;
        s1 = a1 && instr1_is_store;
        if (rst || rnds_flush) begin
            for (int i = 0; i < NS; i++) m_live[i] = 1'b0;
            e_v0 = 1'b0; e_t0 = '0; e_v1 = 1'b0; e_t1 = '0;
            return;
        end
        retire = st_issue_valid && m_live[st_issue_ssid] && m_tag[st_issue_ssid] == st_issue_tag;
        if (rnds_stall) begin
            if (st_issue_valid && st_issue_tag == e_t0) e_v0 = 1'b0;
            if (st_issue_valid && st_issue_tag == e_t1) e_v1 = 1'b0;
        end else begin
            look(a0, int'(instr0_ssid), retire, e_v0, e_t0);
            if (s0 && a1 && instr0_ssid == instr1_ssid) begin
                e_v1 = 1'b1; e_t1 = instr0_tag;
            end else begin
                look(a1, int'(instr1_ssid), retire, e_v1, e_t1);
            end
        end
        if (retire) m_live[st_issue_ssid] = 1'b0;
        if (!rnds_stall) begin
            if (s0) begin m_live[instr0_ssid] = 1'b1; m_tag[instr0_ssid] = instr0_tag; end
            if (s1) begin m_live[instr1_ssid] = 1'b1; m_tag[instr1_ssid] = instr1_tag; end
        end
    endtask

    task automatic chk(input string tagname, input logic [TW-1:0] got, input logic [TW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tagname, got, exp);
        end
    endtask

    // Apply current inputs for one cycle, then compare all registered outputs.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("dep0_valid", TW'(instr0_dep_valid), TW'(e_v0));
        chk("dep0_tag",   instr0_dep_tag, e_t0);
        chk("dep1_valid", TW'(instr1_dep_valid), TW'(e_v1));
        chk("dep1_tag",   instr1_dep_tag, e_t1);
        idle();
    endtask

    // Directed-value check on top of the model comparison.
    task automatic want(input string nm, input bit v, input int t);
        chk(nm, TW'(instr0_dep_valid), TW'(v));
        if (v) chk({nm, "_tag"}, instr0_dep_tag, TW'(t));
    endtask

    initial begin
        idle();
        rst = 1'b1; tick(); tick();
        want("reset", 1'b0, 0);

        // Load before any store
        slot0(1, 0, 5, 0); tick(); want("ld_empty", 1'b0, 0);
        // Store then load
        slot0(0, 1, 5, 3); tick();
        slot0(1, 0, 5, 0); tick(); want("st_then_ld", 1'b1, 3);
        // Intra-bundle bypass
        slot0(0, 1, 9, 4); slot1(1, 0, 9, 0); tick();
        chk("bypass_v", TW'(instr1_dep_valid), TW'(1)); chk("bypass_t", instr1_dep_tag, TW'(4));
        // Slot 1 write priority
        slot0(0, 1, 9, 6); slot1(0, 1, 9, 7); tick();
        slot0(1, 0, 9, 0); tick(); want("slot1_wins", 1'b1, 7);
        // Matching issue retires the entry
        slot0(0, 1, 2, 8); tick();
        issue(2, 8); tick();
        slot0(1, 0, 2, 0); tick(); want("inv_match", 1'b0, 0);
        // Non-matching issue leaves it
        slot0(0, 1, 2, 8); tick();
        issue(2, 1); tick();
        slot0(1, 0, 2, 0); tick(); want("inv_nomatch", 1'b1, 8);
        // Same-cycle lookup with matching issue
        slot0(1, 0, 2, 0); issue(2, 8); tick(); want("inv_same_cyc", 1'b0, 0);
        // Stall: held dependence dropped by issue; stalled store not written
        slot0(0, 1, 5, 3); tick();
        slot0(1, 0, 5, 0); tick(); want("pre_stall", 1'b1, 3);
        rnds_stall = 1'b1; tick(); want("stall_hold", 1'b1, 3);
        rnds_stall = 1'b1; issue(20, 3); tick(); want("stall_drop", 1'b0, 0);
        rnds_stall = 1'b1; slot0(0, 1, 11, 12); tick();
        slot0(1, 0, 11, 0); tick(); want("stall_nowrite", 1'b0, 0);
        // Flush
        slot0(0, 1, 1, 1); slot1(0, 1, 2, 2); tick();
        slot0(0, 1, 3, 3); slot1(1, 0, 1, 0); tick();
        rnds_flush = 1'b1; slot0(1, 0, 1, 0); tick(); want("flush_out", 1'b0, 0);
        for (int s = 1; s <= 3; s++) begin
            slot0(1, 0, s, 0); tick(); want("post_flush", 1'b0, 0);
        end
        // Dispatch write beats same-cycle retire
        slot0(0, 1, 4, 9); tick();
        slot0(0, 1, 4, 10); issue(4, 9); tick();
        slot0(1, 0, 4, 0); tick(); want("write_beats_inv", 1'b1, 10);

        // Randomized traffic on a few sets and tags to force collisions
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 9) < 8) slot0($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                                                 $urandom_range(0, 3), $urandom_range(0, 5));
            if ($urandom_range(0, 9) < 8) slot1($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                                                 $urandom_range(0, 3), $urandom_range(0, 5));
            instr0_ssid_valid = ($urandom_range(0, 9) != 0) && instr0_valid;
            instr1_ssid_valid = ($urandom_range(0, 9) != 0) && instr1_valid;
            if ($urandom_range(0, 2) == 0) issue($urandom_range(0, 3), $urandom_range(0, 5));
            rnds_stall = ($urandom_range(0, 5) == 0);
            rnds_flush = ($urandom_range(0, 40) == 0);
            rst        = ($urandom_range(0, 150) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
